// File: rtl/corelet_ctrl.sv
// Weight-stationary tile-pass controller for a row x col corelet: loads weights, flushes, streams activations, executes, drains OFIFO.
// Optional build macro CORELET_CTRL_RELU_EN routes the registered accumulate strobe onto sfu_relu.
module corelet_ctrl #(
  parameter int row = 8,
  parameter int col = 8,
  parameter int cw  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [cw-1:0] len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          ofifo_valid,
  output logic          ld_mode,
  output logic          l0_wr,
  output logic          l0_rd,
  output logic          kflush,
  output logic          execute,
  output logic          os_or_ws,
  output logic          ofifo_rd,
  output logic          sfu_acc,
  output logic          sfu_relu,
  output logic          busy,
  output logic          done,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_WLD, S_WFLUSH, S_ALD, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  localparam logic [cw-1:0] wld_last   = cw'(row - 1);
  localparam logic [cw-1:0] flush_last = cw'(row + col - 1);
  localparam logic [cw-1:0] one        = cw'(1);

  state_t        state, state_n;
  logic [cw-1:0] cnt, cnt_n;
  logic [cw-1:0] len_q, len_n;
  logic [cw-1:0] len_last;

  // Every phase exits at its terminal count, so cnt never needs to wrap.
  assign len_last  = len_q - one;
  assign os_or_ws  = 1'b0;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      len_q   <= '0;
      sfu_acc <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      len_q   <= len_n;
      sfu_acc <= ofifo_rd;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    len_n    = len_q;
    in_ready = 1'b0;
    ld_mode  = 1'b0;
    l0_wr    = 1'b0;
    l0_rd    = 1'b0;
    kflush   = 1'b0;
    execute  = 1'b0;
    ofifo_rd = 1'b0;
    done     = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start && (len != '0)) begin
          state_n = S_WLD;
          cnt_n   = '0;
          len_n   = len;
        end
      end
      S_WLD: begin
        in_ready = 1'b1;
        ld_mode  = 1'b1;
        l0_wr    = in_valid;
        if (in_valid) begin
          if (cnt == wld_last) begin
            state_n = S_WFLUSH;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + one;
          end
        end
      end
      S_WFLUSH: begin
        l0_rd  = 1'b1;
        kflush = 1'b1;
        if (cnt == flush_last) begin
          state_n = S_ALD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + one;
        end
      end
      S_ALD: begin
        in_ready = 1'b1;
        ld_mode  = 1'b1;
        l0_wr    = in_valid;
        if (in_valid) begin
          if (cnt == len_last) begin
            state_n = S_EXEC;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + one;
          end
        end
      end
      S_EXEC: begin
        l0_rd   = 1'b1;
        execute = 1'b1;
        if (cnt == len_last) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + one;
        end
      end
      S_DRAIN: begin
        ofifo_rd = ofifo_valid;
        if (ofifo_valid) begin
          if (cnt == len_last) begin
            state_n = S_DONE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + one;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

`ifdef CORELET_CTRL_RELU_EN
  assign sfu_relu = sfu_acc;
`else
  assign sfu_relu = 1'b0;
`endif

endmodule

// File: tb/tb_corelet_ctrl.sv
// Bench for corelet_ctrl: randomized passes checked cycle by cycle against a phase-table model plus per-pass event totals.
module tb_corelet_ctrl;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int CW  = 8;

  localparam int P_IDLE  = 0;
  localparam int P_WLD   = 1;
  localparam int P_FLUSH = 2;
  localparam int P_ALD   = 3;
  localparam int P_EXEC  = 4;
  localparam int P_DRAIN = 5;
  localparam int P_DONE  = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] len;
  logic          in_valid;
  logic          in_ready;
  logic          ofifo_valid;
  logic          ld_mode, l0_wr, l0_rd, kflush, execute, os_or_ws;
  logic          ofifo_rd, sfu_acc, sfu_relu, busy, done;
  logic [2:0]    state_dbg;

  int checks   = 0;
  int failures = 0;

  // Model: a pass is a list of phases, each lasting a fixed number of advancing cycles.
  int   m_ph;
  int   m_k;
  int   m_len;
  int   m_dones;
  logic m_acc;

  logic [11:0] exp_v;
  logic [11:0] obs_v;

  corelet_ctrl #(.row(ROW), .col(COL), .cw(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .ofifo_valid(ofifo_valid),
    .ld_mode(ld_mode), .l0_wr(l0_wr), .l0_rd(l0_rd), .kflush(kflush),
    .execute(execute), .os_or_ws(os_or_ws), .ofifo_rd(ofifo_rd),
    .sfu_acc(sfu_acc), .sfu_relu(sfu_relu), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic int need(int ph);
    case (ph)
      P_WLD:                  return ROW;
      P_FLUSH:                return ROW + COL;
      P_ALD, P_EXEC, P_DRAIN: return m_len;
      default:                return 1;
    endcase
  endfunction

  function automatic logic [11:0] model_out();
    logic b, ir, lm, wr, rd, kf, ex, orr, dn, relu;
    b = (m_ph != P_IDLE);
    {ir, lm, wr, rd, kf, ex, orr, dn} = '0;
    case (m_ph)
      P_WLD, P_ALD: begin ir = 1'b1; lm = 1'b1; wr = in_valid; end
      P_FLUSH:      begin rd = 1'b1; kf = 1'b1; end
      P_EXEC:       begin rd = 1'b1; ex = 1'b1; end
      P_DRAIN:      orr = ofifo_valid;
      P_DONE:       dn = 1'b1;
      default:      ;
    endcase
`ifdef CORELET_CTRL_RELU_EN
    relu = m_acc;
`else
    relu = 1'b0;
`endif
    return {b, ir, lm, wr, rd, kf, ex, orr, dn, 1'b0, m_acc, relu};
  endfunction

  function automatic logic [11:0] dut_out();
    return {busy, in_ready, ld_mode, l0_wr, l0_rd, kflush, execute, ofifo_rd,
            done, os_or_ws, sfu_acc, sfu_relu};
  endfunction

  task automatic model_reset();
    m_ph  = P_IDLE;
    m_k   = 0;
    m_acc = 1'b0;
  endtask

  // Advance the model with the inputs currently driven, then move to the next falling edge.
  task automatic tick();
    logic acc_n;
    logic adv;
    acc_n = (m_ph == P_DRAIN) && ofifo_valid;
    if (m_ph == P_IDLE) begin
      if (start && (len != '0)) begin
        m_ph  = P_WLD;
        m_k   = 0;
        m_len = int'(len);
      end
    end else begin
      if (m_ph == P_WLD || m_ph == P_ALD) adv = in_valid;
      else if (m_ph == P_DRAIN)           adv = ofifo_valid;
      else                                adv = 1'b1;
      if (m_ph == P_DONE) m_dones++;
      if (adv) begin
        m_k++;
        if (m_k == need(m_ph)) begin
          m_ph = (m_ph == P_DONE) ? P_IDLE : m_ph + 1;
          m_k  = 0;
        end
      end
    end
    m_acc = acc_n;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; len = 8'd5; in_valid = 1'b1; ofifo_valid = 1'b1;
    model_reset();
    m_dones = 0;
    #1;
    checks++;
    if (dut_out() !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=%h", dut_out(), 12'h000);
    end
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
  endtask

  task automatic test_nominal();
    int got[9];
    int want[9];
    bit finished;
    got = '{default: 0};
    finished = 1'b0;
    len = 8'd4;
    for (int c = 0; c < 300; c++) begin
      start = (c == 0); in_valid = 1'b1; ofifo_valid = 1'b1;
      #1;
      exp_v = model_out(); obs_v = dut_out();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL nominal_cycle c=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      if (l0_wr && got[1] == 0) got[0]++;
      if (l0_wr && got[1] != 0) got[2]++;
      got[1] += int'(kflush);
      got[3] += int'(execute);
      got[4] += int'(ofifo_rd);
      got[5] += int'(done);
      got[6] += int'(sfu_relu);
      if (c >= 1 && !finished && !busy) got[7]++;
      if (done) finished = 1'b1;
      tick();
      if (finished && m_ph == P_IDLE) break;
    end
    got[8] = int'(finished);
`ifdef CORELET_CTRL_RELU_EN
    want = '{8, 16, 4, 4, 4, 1, 4, 0, 1};
`else
    want = '{8, 16, 4, 4, 4, 1, 0, 0, 1};
`endif
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        failures++;
        $display("FAIL nominal_count idx=%0d got=%0d want=%0d", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lw;
    int wr_w, wr_a, kf;
    bit finished;
    lw = $urandom_range(1, 6);
    len = CW'(lw);
    wr_w = 0; wr_a = 0; kf = 0; finished = 1'b0;
    for (int c = 0; c < 400; c++) begin
      start = (c == 0); in_valid = (c % 2 == 0); ofifo_valid = 1'b1;
      #1;
      exp_v = model_out(); obs_v = dut_out();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL backpressure_cycle c=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      if (l0_wr && kf == 0) wr_w++;
      if (l0_wr && kf != 0) wr_a++;
      kf += int'(kflush);
      if (done) finished = 1'b1;
      tick();
      if (finished && m_ph == P_IDLE) break;
    end
    checks++;
    if (!finished || wr_w != ROW || wr_a != lw) begin
      failures++;
      $display("FAIL backpressure_writes got=%0d/%0d done=%0d want=%0d/%0d", wr_w, wr_a, finished, ROW, lw);
    end
  endtask

  task automatic test_ofifo_stall();
    int stall, rd, acc, stall_hits, acc_bad;
    logic prev_rd;
    bit finished;
    stall = 0; rd = 0; acc = 0; stall_hits = 0; acc_bad = 0; prev_rd = 1'b0; finished = 1'b0;
    len = 8'd4;
    for (int c = 0; c < 300; c++) begin
      start = (c == 0); in_valid = 1'b1;
      ofifo_valid = !(m_ph == P_DRAIN && stall < 10);
      #1;
      exp_v = model_out(); obs_v = dut_out();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL ofifo_stall_cycle c=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      if (!ofifo_valid) begin
        stall++;
        if (ofifo_rd || done) stall_hits++;
      end
      if (sfu_acc !== prev_rd) acc_bad++;
      prev_rd = ofifo_rd;
      rd += int'(ofifo_rd);
      acc += int'(sfu_acc);
      if (done) finished = 1'b1;
      tick();
      if (finished && m_ph == P_IDLE) break;
    end
    #1;
    acc += int'(sfu_acc);
    checks++;
    if (!finished || stall != 10 || stall_hits != 0 || rd != 4 || acc != 4 || acc_bad != 0) begin
      failures++;
      $display("FAIL ofifo_stall_summary done=%0d stall=%0d hits=%0d rd=%0d acc=%0d accbad=%0d want 1/10/0/4/4/0",
               finished, stall, stall_hits, rd, acc, acc_bad);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    int busy_seen, d0;
    bit finished;
    busy_seen = 0; finished = 1'b0;
    len = 8'd0;
    for (int c = 0; c < 6; c++) begin
      start = (c == 0); in_valid = 1'b1; ofifo_valid = 1'b1;
      #1;
      busy_seen += int'(busy);
      tick();
    end
    checks++;
    if (busy_seen != 0 || m_ph != P_IDLE) begin
      failures++;
      $display("FAIL len_zero_busy got=%0d want=0", busy_seen);
    end
    d0 = m_dones;
    for (int c = 0; c < 400; c++) begin
      start = (c == 0) || (m_ph == P_EXEC) || (finished && c % 2 == 0);
      len = (c == 0) ? 8'd3 : CW'($urandom_range(1, 9));
      in_valid = 1'b1; ofifo_valid = 1'b1;
      #1;
      exp_v = model_out(); obs_v = dut_out();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL illegal_start_cycle c=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      if (done) finished = 1'b1;
      if (finished) start = 1'b0;
      tick();
      if (finished && m_ph == P_IDLE) break;
    end
    start = 1'b0;
    checks++;
    if (!finished || m_dones - d0 != 1) begin
      failures++;
      $display("FAIL illegal_start_dones got=%0d want=1", m_dones - d0);
    end
  endtask

  task automatic test_reset_mid_exec();
    int dn, rd;
    bit finished;
    dn = 0; rd = 0; finished = 1'b0;
    len = 8'd5;
    for (int c = 0; c < 300; c++) begin
      start = (c == 0); in_valid = 1'b1; ofifo_valid = 1'b1;
      #1;
      exp_v = model_out(); obs_v = dut_out();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL reset_exec_cycle c=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      dn += int'(done);
      if (m_ph == P_EXEC && m_k == 2) break;
      tick();
    end
    reset = 1'b0; start = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_out() !== 12'h000) begin
      failures++;
      $display("FAIL reset_exec_assert got=%h want=%h", dut_out(), 12'h000);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut_out() !== 12'h000) begin
      failures++;
      $display("FAIL reset_exec_hold got=%h want=%h", dut_out(), 12'h000);
    end
    @(negedge clk);
    reset = 1'b1;
    len = 8'd2;
    for (int c = 0; c < 300; c++) begin
      start = (c == 0); in_valid = 1'b1; ofifo_valid = 1'b1;
      #1;
      exp_v = model_out(); obs_v = dut_out();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL reset_restart_cycle c=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      rd += int'(ofifo_rd);
      if (done) begin finished = 1'b1; dn++; end
      tick();
      if (finished && m_ph == P_IDLE) break;
    end
    checks++;
    if (dn != 1 || rd != 2) begin
      failures++;
      $display("FAIL reset_restart_summary dones=%0d rd=%0d want 1/2", dn, rd);
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 4; p++) begin
      bit finished;
      int lp;
      finished = 1'b0;
      lp = $urandom_range(1, 7);
      for (int c = 0; c < 500; c++) begin
        start = (c == 0) || ($urandom_range(0, 7) == 0);
        len = (c == 0) ? CW'(lp) : CW'($urandom_range(0, 9));
        in_valid = ($urandom_range(0, 2) != 0);
        ofifo_valid = ($urandom_range(0, 2) != 0);
        if (finished) start = 1'b0;
        #1;
        exp_v = model_out(); obs_v = dut_out();
        checks++;
        if (obs_v !== exp_v) begin
          failures++;
          $display("FAIL random_cycle p=%0d c=%0d got=%h want=%h", p, c, obs_v, exp_v);
        end
        if (done) finished = 1'b1;
        tick();
        if (finished && m_ph == P_IDLE) break;
      end
      checks++;
      if (!finished) begin
        failures++;
        $display("FAIL random_timeout p=%0d got=0 want=1", p);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_ofifo_stall();
    test_illegal();
    test_reset_mid_exec();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
